nibble_serial_adder: RTL
========================

Name: nibble_serial_adder

Overview:
- Multi-cycle wide-operand adder. Splits WIDTH-bit operands into 4-bit nibbles and adds one nibble per cycle, LSB first, through a 4-bit carry-lookahead slice.
- Carry between nibbles is held in a register.
- Sits directly upstream of the datapath consumer and presents the 4-bit CLA to the rest of the design as a valid/ready arithmetic stage.
- Gives area-cheap wide addition at the cost of WIDTH/4 cycles of latency.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand handshake valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  operand A, sampled on input handshake
- b  input  WIDTH  operand B, sampled on input handshake
- cin  input  1  carry-in, sampled on input handshake
- out_valid  output  1  sum/cout valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered result
- cout  output  1  registered carry-out of the MSB nibble
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low via rst_n. Reset forces IDLE, out_valid=0, sum=0, cout=0, busy=0, carry register=0, nibble counter=0. in_ready=1 as soon as rst_n is low.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, load the a/b shift registers, load cin into the carry register, clear the counter, go to RUN.
  - RUN: each cycle, add the low nibble of A_sh, the low nibble of B_sh and the carry register in the CLA slice. Shift the 4-bit result into the top of the sum shift register (right shift by 4). Shift A_sh/B_sh right by 4. Update the carry register with the slice carry-out and increment the counter. When counter==NIB-1, go to DONE.
  - DONE: out_valid=1; sum and cout are stable. On out_ready, drop out_valid and go to IDLE.
- Latency: out_valid rises exactly NIB cycles after the accepting edge. Minimum initiation interval is NIB+2 cycles.
- Arithmetic: sum = (a+b+cin) mod 2^WIDTH; cout = bit WIDTH of that sum. Intermediate carries exist only in the carry register.
- in_valid outside IDLE is ignored; operands are captured only at the handshake.
- out_ready asserted while out_valid=0 has no effect.
- Backpressure: DONE holds indefinitely with sum/cout frozen.
- WIDTH=4: a single RUN cycle.
- Reset mid-RUN or mid-DONE: the result is discarded immediately and no out_valid pulse follows.
- sum/cout change only in RUN (sum shifts progressively) and at reset. Consumers sample only when out_valid=1.

Optional Feature:
- Macro: NIBBLE_SERIAL_SUB_EN.
- With the macro: adds input port sub (1 bit), sampled at the input handshake. When sub=1, B_sh loads ~b and the carry register loads 1, ignoring cin. The result is a-b mod 2^WIDTH, and cout=1 means no borrow (a>=b unsigned).
- Without the macro: the port is absent and the block is add-only.

Decomposition:
- Shared package nibble_serial_pkg:
  - state typedef enum {IDLE, RUN, DONE}
  - localparam NIBBLE_W=4
  - a function computing the counter width, $clog2(NIB) with a minimum of 1
- One sub-module: cla4_slice. It is purely combinational: 4-bit a, b, cin -> 4-bit s, cout. It uses generate/propagate lookahead, with c[i+1]=g[i]|p[i]&c[i] expanded.

Test Plan (WIDTH=16 unless noted):
- 0xFFFF+0x0001, cin=0 -> after 4 cycles out_valid=1, sum=0x0000, cout=1 (carry ripples through every nibble).
- 0x1234+0x4321, cin=1 -> sum=0x5556, cout=0. in_ready=0 for the whole operation.
- Result held with out_ready=0 for 10 cycles -> sum/cout/out_valid unchanged. Release -> IDLE the next cycle, then a back-to-back op 0x8000+0x8000 gives sum=0x0000, cout=1.
- rst_n pulsed low in the 2nd RUN cycle -> outputs cleared asynchronously, in_ready=1, no out_valid ever for that op. A new op 0x0001+0x0001 gives 0x0002.
- WIDTH=4 instance: 0xF+0xF, cin=1 -> out_valid 1 cycle after accept, sum=0xF, cout=1.
- NIBBLE_SERIAL_SUB_EN: 0x0005-0x0007 -> sum=0xFFFE, cout=0. 0x0007-0x0005 -> sum=0x0002, cout=1.

Source files
------------

// File: rtl/nibble_serial_pkg.sv
// Shared types and helpers for the nibble-serial adder.
// Optional subtract support is enabled with NIBBLE_SERIAL_SUB_EN.
package nibble_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    // Counter width for a nibble index, never narrower than one bit.
    function automatic int cnt_width(input int nib);
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// 4-bit carry-lookahead adder slice, purely combinational.
// Carries are fully expanded generate/propagate terms.
module cla4_slice (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_s,
    output logic       o_cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    // Generate/propagate terms and flattened lookahead carries.
    always_comb begin
        w_g    = i_a & i_b;
        w_p    = i_a ^ i_b;
        w_c[0] = i_cin;
        w_c[1] = w_g[0]
               | (w_p[0] & i_cin);
        w_c[2] = w_g[1]
               | (w_p[1] & w_g[0])
               | (w_p[1] & w_p[0] & i_cin);
        w_c[3] = w_g[2]
               | (w_p[2] & w_g[1])
               | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & i_cin);
        w_c[4] = w_g[3]
               | (w_p[3] & w_g[2])
               | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);
        o_s    = w_p ^ w_c[3:0];
        o_cout = w_c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that processes one nibble per cycle, LSB first.
// Define NIBBLE_SERIAL_SUB_EN to add the sub input (a-b mode).
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int CW  = cnt_width(NIB);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [3:0]       w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_sum_next;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic             w_last;

    cla4_slice u_cla (
        .i_a    (r_a[3:0]),
        .i_b    (r_b[3:0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_c)
    );

    // New nibble enters at the top; older nibbles move toward bit 0.
    generate
        if (WIDTH == NIBBLE_W) begin : g_one
            always_comb w_sum_next = w_s;
        end else begin : g_many
            always_comb w_sum_next = {w_s, r_sum[WIDTH-1:NIBBLE_W]};
        end
    endgenerate

    // Operand/carry selection at the input handshake.
    always_comb begin
`ifdef NIBBLE_SERIAL_SUB_EN
        w_b_load = sub ? ~b : b;
        w_c_load = sub ? 1'b1 : cin;
`else
        w_b_load = b;
        w_c_load = cin;
`endif
        w_last = (r_cnt == CW'(NIB - 1));
    end

    // Control FSM with the datapath shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= w_b_load;
                        r_carry    <= w_c_load;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_next;
                    r_a     <= r_a >> NIBBLE_W;
                    r_b     <= r_b >> NIBBLE_W;
                    r_carry <= w_c;
                    r_cout  <= w_c;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign busy      = r_busy;

endmodule
